data_memory_responder: RTL

//  Wait-state data-memory responder on the M-stage side of the 5-stage RV32 pipeline.
//  It accepts load/store requests from the memory pipeline register and services them

---
 rtl/data_memory_responder_if.sv | 28 ++
 rtl/data_memory_responder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/data_memory_responder_if.sv
//------------------------------------------------------------------------------
// Module : data_memory_responder_if
// Brief  : M-stage load/store request bus between the pipeline and the responder.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface data_memory_responder_if;
    logic        memread_M;
    logic        memwrite_M;
    logic [31:0] addr_M;
    logic [31:0] writedata_M;
    logic [31:0] readdata_M;
    logic        mem_busy;
    logic        mem_err;

    modport master (
        output memread_M, memwrite_M, addr_M, writedata_M,
        input  readdata_M, mem_busy, mem_err
    );

    modport slave (
        input  memread_M, memwrite_M, addr_M, writedata_M,
        output readdata_M, mem_busy, mem_err
    );
endinterface

`default_nettype wire

// File: rtl/data_memory_responder.sv
//------------------------------------------------------------------------------
// Module : data_memory_responder
// Brief  : Wait-state data memory for the M stage; stalls via mem_busy, registered reads.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  wire                    clk,
    input  wire                    rst,
    data_memory_responder_if.slave bus
);
    localparam int         ADDR_W   = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic [3:0]        cnt_next;
    logic [ADDR_W-1:0] lat_idx;
    logic [31:0]       lat_data;
    logic              lat_we;
    logic [31:0]       mem [DEPTH_WORDS];

    logic              req;
    logic              aligned;
    logic [ADDR_W-1:0] in_idx;
    logic              latch_en;
    logic              acc_en;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_idx;
    logic [31:0]       acc_data;
    logic              err_next;
    logic              unused_addr_hi;

    assign req            = bus.memread_M | bus.memwrite_M;
    assign aligned        = (bus.addr_M[1:0] == 2'b00);
    assign in_idx         = bus.addr_M[ADDR_W+1:2];
    assign unused_addr_hi = ^bus.addr_M[31:ADDR_W+2];

    assign bus.mem_busy = ((state == S_IDLE) && req && aligned) || (state == S_WAIT);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        latch_en   = 1'b0;
        acc_en     = 1'b0;
        acc_we     = lat_we;
        acc_idx    = lat_idx;
        acc_data   = lat_data;
        err_next   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (aligned) begin
                        latch_en = 1'b1;
                        cnt_next = CNT_INIT;
                        err_next = bus.memread_M & bus.memwrite_M;
                        // Single wait state: the access happens on the request edge itself.
                        if (WAIT_STATES == 1) begin
                            acc_en     = 1'b1;
                            acc_we     = bus.memwrite_M;
                            acc_idx    = in_idx;
                            acc_data   = bus.writedata_M;
                            state_next = S_DONE;
                        end else begin
                            state_next = S_WAIT;
                        end
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd1) begin
                    acc_en     = 1'b1;
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= 4'd0;
            lat_idx        <= '0;
            lat_data       <= 32'd0;
            lat_we         <= 1'b0;
            bus.readdata_M <= 32'd0;
            bus.mem_err    <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            bus.mem_err <= err_next;
            if (latch_en) begin
                lat_idx  <= in_idx;
                lat_data <= bus.writedata_M;
                lat_we   <= bus.memwrite_M;
            end
            if (acc_en && !acc_we) begin
                bus.readdata_M <= mem[acc_idx];
            end
        end
    end

    // Storage is not cleared by reset, but a store landing on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!rst && acc_en && acc_we) begin
            mem[acc_idx] <= acc_data;
        end
    end
endmodule

`default_nettype wire
